// File: rtl/final2_soc_nios2_qsys_0_oci_dct_monitor.sv
// OCI DCT monitor: captures each new DCT word into a FIFO, tracks test-end state, exposes readback.
// Define OCI_DCT_MON_WRAP_EN to overwrite the oldest entry on a full capture instead of dropping.
module final2_soc_nios2_qsys_0_oci_dct_monitor #(
    parameter int unsigned DATA_W = 30,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] dct_buffer,
    input  logic [CNT_W-1:0]  dct_count,
    input  logic              test_ending,
    input  logic              test_has_ended,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   fill_level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count,
    output logic [1:0]        mon_state,
    output logic              done
);

`ifdef OCI_DCT_MON_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    localparam logic [ADDR_W:0] FullLevel = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StDrain   = 2'd2,
        StEnded   = 2'd3
    } mon_state_e;

    mon_state_e          state_q, state_d;
    logic [CNT_W-1:0]    prev_count_q;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                overflow_q;
    logic [DROP_W-1:0]   drop_q;
    logic                done_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic new_word, capture, is_full, is_empty, pop, push, lost, overwrite;

    always_comb begin
        new_word  = (dct_count != prev_count_q);
        capture   = new_word && (state_q == StIdle || state_q == StCapture);
        is_full   = (count_q == FullLevel);
        is_empty  = (count_q == '0);
        pop       = rd_en && !is_empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push      = capture && (!is_full || pop);
        lost      = capture && is_full && !pop;
        overwrite = WrapEn && lost;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (ADDR_W + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (ADDR_W + 1)'(1);
        end

        wr_ptr_d = wr_ptr_q;
        if (push || overwrite) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        rd_ptr_d = rd_ptr_q;
        if (pop || overwrite) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (test_ending || test_has_ended) begin
                    state_d = StDrain;
                end else if (new_word) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (test_ending || test_has_ended) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Judged on post-pop occupancy so the last pop and the exit share a cycle.
                if (test_has_ended && count_d == '0) begin
                    state_d = StEnded;
                end
            end
            StEnded: state_d = StEnded;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            prev_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            overflow_q   <= 1'b0;
            drop_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_count_q <= dct_count;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_valid_q   <= pop;
            done_q       <= (state_d == StEnded);
            if (pop) begin
                rd_data_q <= mem[rd_ptr_q];
            end
            if (lost) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) begin
                    drop_q <= drop_q + DROP_W'(1);
                end
            end
        end
    end

    // Storage is not reset; fill_level = 0 makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push || overwrite) begin
            mem[wr_ptr_q] <= dct_buffer;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign fill_level = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign mon_state  = state_q;
    assign done       = done_q;

endmodule

// File: tb/tb_final2_soc_nios2_qsys_0_oci_dct_monitor.sv
// Directed bench for the OCI DCT monitor with a queue scoreboard of expected popped words.
module tb_final2_soc_nios2_qsys_0_oci_dct_monitor;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [29:0] dct_buffer = '0;
    logic [3:0]  dct_count = '0;
    logic        test_ending = 1'b0;
    logic        test_has_ended = 1'b0;
    logic        rd_en = 1'b0;
    logic [29:0] rd_data;
    logic        rd_valid;
    logic [4:0]  fill_level;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [1:0]  mon_state;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [29:0] exp_q [$];
    logic [29:0] last_word;

    final2_soc_nios2_qsys_0_oci_dct_monitor dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .dct_buffer    (dct_buffer),
        .dct_count     (dct_count),
        .test_ending   (test_ending),
        .test_has_ended(test_has_ended),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .fill_level    (fill_level),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .mon_state     (mon_state),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        dct_count = '0;
        rd_en = 1'b0;
        test_ending = 1'b0;
        test_has_ended = 1'b0;
        exp_q.delete();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Present a new DCT word; 'accept' says whether the scoreboard expects it stored.
    task automatic new_word(input logic [29:0] w, input bit accept);
        dct_buffer = w;
        dct_count  = dct_count + 4'd1;
        tick();
        if (accept) exp_q.push_back(w);
    endtask

    task automatic pop_check(input string tag);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            last_word = exp_q.pop_front();
            check({tag, "_data"}, 32'(rd_data), 32'(last_word));
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_state", 32'(mon_state), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);

        // First capture and single readback
        new_word(30'h1234567, 1'b1);
        check("first_state", 32'(mon_state), 32'd1);
        check("first_fill", 32'(fill_level), 32'd1);
        pop_check("first_pop");
        check("first_fill_after", 32'(fill_level), 32'd0);
        tick();
        check("valid_strobe", 32'(rd_valid), 32'd0);

        // 20 captures into 16 entries
        for (int i = 1; i <= 20; i++) begin
            if (exp_q.size() < 16) begin
                new_word(30'h100 + 30'(i), 1'b1);
            end else begin
`ifdef OCI_DCT_MON_WRAP_EN
                void'(exp_q.pop_front());
                new_word(30'h100 + 30'(i), 1'b1);
`else
                new_word(30'h100 + 30'(i), 1'b0);
`endif
            end
        end
        check("ovf_fill", 32'(fill_level), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drop", 32'(drop_count), 32'd4);
        for (int i = 0; i < 16; i++) pop_check("ovf_pop");
        check("ovf_fill_end", 32'(fill_level), 32'd0);

        // Full FIFO with simultaneous pop and push
        do_reset();
        for (int i = 1; i <= 16; i++) new_word(30'h200 + 30'(i), 1'b1);
        check("sim_fill_full", 32'(fill_level), 32'd16);
        rd_en = 1'b1;
        dct_buffer = 30'h2FF;
        dct_count = dct_count + 4'd1;
        tick();
        rd_en = 1'b0;
        check("sim_valid", 32'(rd_valid), 32'd1);
        last_word = exp_q.pop_front();
        check("sim_data", 32'(rd_data), 32'(last_word));
        exp_q.push_back(30'h2FF);
        check("sim_fill", 32'(fill_level), 32'd16);
        check("sim_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) pop_check("sim_pop");
        check("sim_last", 32'(last_word), 32'h2FF);

        // Drain and end sequence
        for (int i = 1; i <= 3; i++) new_word(30'h300 + 30'(i), 1'b1);
        test_ending = 1'b1;
        tick();
        check("drain_state", 32'(mon_state), 32'd2);
        new_word(30'h3AA, 1'b0);
        check("drain_nocap", 32'(fill_level), 32'd3);
        test_has_ended = 1'b1;
        tick();
        check("drain_hold", 32'(mon_state), 32'd2);
        pop_check("drain_pop1");
        pop_check("drain_pop2");
        check("drain_still", 32'(mon_state), 32'd2);
        pop_check("drain_pop3");
        check("ended_state", 32'(mon_state), 32'd3);
        check("ended_done", 32'(done), 32'd1);
        new_word(30'h3BB, 1'b0);
        check("ended_nocap", 32'(fill_level), 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("empty_valid", 32'(rd_valid), 32'd0);
        check("empty_hold", 32'(rd_data), 32'(last_word));

        // Asynchronous reset pulse between edges
        do_reset();
        for (int i = 1; i <= 17; i++) new_word(30'h400 + 30'(i), 1'b0);
        check("pre_pulse_ovf", 32'(overflow), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("pulse_fill", 32'(fill_level), 32'd0);
        check("pulse_ovf", 32'(overflow), 32'd0);
        check("pulse_state", 32'(mon_state), 32'd0);
        reset_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
